i2c_master_core: RTL and testbench

I2C_MASTER_CORE -- requirements
Module: i2c_master_core

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_clkgen.sv | 34 +++
 rtl/i2c_master_core.sv | 172 +++++++++++++++++
 tb/tb_i2c_master_core.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state codes and the four bit-phase quarters,
// usable by both master and slave side logic.
package i2c_pkg;

   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_START     = 4'd1;
   localparam logic [3:0] ST_ADDR      = 4'd2;
   localparam logic [3:0] ST_ADDR_ACK  = 4'd3;
   localparam logic [3:0] ST_WRITE     = 4'd4;
   localparam logic [3:0] ST_WRITE_ACK = 4'd5;
   localparam logic [3:0] ST_READ      = 4'd6;
   localparam logic [3:0] ST_READ_ACK  = 4'd7;
   localparam logic [3:0] ST_STOP      = 4'd8;

   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;

   // States that clock one SCL bit per four quarters
   function automatic logic is_bit_state(input logic [3:0] s);
      return (s == ST_ADDR) || (s == ST_ADDR_ACK) || (s == ST_WRITE) ||
             (s == ST_WRITE_ACK) || (s == ST_READ) || (s == ST_READ_ACK);
   endfunction

endpackage

// File: rtl/i2c_clkgen.sv
// Quarter-period tick generator for the I2C master; freezes while a slave
// stretches SCL during the released quarter.
module i2c_clkgen #(
   parameter int CLK_DIV = 250
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic stretch,
   input  logic scl_in,
   output logic tick
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;
   logic          hold;

   assign hold = stretch && !scl_in;
   assign tick = (cnt == '0) && !hold;

   // Holding at the reload value keeps the whole high phase intact after a stretch
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load || tick) begin
         cnt <= RELOAD;
      end else if (!hold) begin
         cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/i2c_master_core.sv
// I2C master: START, address byte, one write or read byte, STOP.
// Open-drain outputs only ever pull low or release.
module i2c_master_core
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 250
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] address,
   input  logic [7:0] datasend,
   output logic [7:0] datareceive,
   output logic       sended,
   output logic       received,
   output logic       ack_error,
   output logic       ready,
   inout  wire        scl,
   inout  wire        sda
);

   logic [3:0] state;
   logic [1:0] phase;
   logic [2:0] bit_cnt;
   logic [7:0] shift;
   logic [7:0] data_q;
   logic       rw_q;
   logic       scl_low;
   logic       sda_low;
   logic       tick;
   logic       load;
   logic       in_bit;
   logic       stretch;
   logic       drive_low;
   logic       sda_in;

   assign scl       = scl_low ? 1'b0 : 1'bz;
   assign sda       = sda_low ? 1'b0 : 1'bz;
   assign sda_in    = sda;
   assign ready     = (state == ST_IDLE);
   assign load      = ready && start;
   assign in_bit    = is_bit_state(state);
   assign stretch   = in_bit && (phase == Q2);
   assign drive_low = ((state == ST_ADDR) || (state == ST_WRITE)) && !shift[7];

   i2c_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .stretch(stretch),
      .scl_in (scl),
      .tick   (tick)
   );

   // SDA is updated in the first Q0 cycle after SCL has already gone low
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         phase       <= Q0;
         bit_cnt     <= 3'd0;
         shift       <= 8'h00;
         data_q      <= 8'h00;
         rw_q        <= 1'b0;
         scl_low     <= 1'b0;
         sda_low     <= 1'b0;
         datareceive <= 8'h00;
         sended      <= 1'b0;
         received    <= 1'b0;
         ack_error   <= 1'b0;
      end else begin
         sended   <= 1'b0;
         received <= 1'b0;
         if (in_bit && (phase == Q0)) begin
            sda_low <= drive_low;
         end
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_START;
                  phase     <= Q0;
                  rw_q      <= rw;
                  data_q    <= datasend;
                  shift     <= {address, rw};
                  sda_low   <= 1'b1;
                  ack_error <= 1'b0;
               end
            end
            ST_START: begin
               if (tick) begin
                  if (phase == Q1) begin
                     state   <= ST_ADDR;
                     phase   <= Q0;
                     bit_cnt <= 3'd7;
                     scl_low <= 1'b1;
                  end else begin
                     phase <= phase + 2'd1;
                  end
               end
            end
            ST_STOP: begin
               if (phase == Q0) begin
                  sda_low <= 1'b1;
               end
               if (tick) begin
                  phase <= phase + 2'd1;
                  case (phase)
                     Q0:      scl_low <= 1'b0;
                     Q1:      sda_low <= 1'b0;
                     Q3:      state   <= ST_IDLE;
                     default: ;
                  endcase
               end
            end
            default: begin
               if (tick) begin
                  phase <= phase + 2'd1;
                  if (phase == Q1) begin
                     scl_low <= 1'b0;
                  end
                  // End of the high quarter: sample and decide the next bit
                  if (phase == Q3) begin
                     scl_low <= 1'b1;
                     case (state)
                        ST_ADDR, ST_WRITE: begin
                           shift   <= {shift[6:0], 1'b0};
                           bit_cnt <= bit_cnt - 3'd1;
                           if (bit_cnt == 3'd0) begin
                              state <= (state == ST_ADDR) ? ST_ADDR_ACK : ST_WRITE_ACK;
                           end
                        end
                        ST_ADDR_ACK: begin
                           bit_cnt <= 3'd7;
                           if (sda_in) begin
                              ack_error <= 1'b1;
                              state     <= ST_STOP;
                           end else if (rw_q) begin
                              state <= ST_READ;
                           end else begin
                              state <= ST_WRITE;
                              shift <= data_q;
                           end
                        end
                        ST_WRITE_ACK: begin
                           if (sda_in) begin
                              ack_error <= 1'b1;
                           end
                           sended <= 1'b1;
                           state  <= ST_STOP;
                        end
                        ST_READ: begin
                           shift   <= {shift[6:0], sda_in};
                           bit_cnt <= bit_cnt - 3'd1;
                           if (bit_cnt == 3'd0) begin
                              state <= ST_READ_ACK;
                           end
                        end
                        ST_READ_ACK: begin
                           datareceive <= shift;
                           received    <= 1'b1;
                           state       <= ST_STOP;
                        end
                        default: state <= ST_IDLE;
                     endcase
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_master_core.sv
// Bench for i2c_master_core: pulled-up open-drain bus plus a behavioural slave
// at 0x3C that logs bytes, ACK bits, START/STOP and can stretch SCL.
module tb_i2c_master_core;

   localparam int CLK_DIV = 4;
   localparam logic [6:0] SLAVE_ADDR = 7'h3C;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       rw;
   logic [6:0] address;
   logic [7:0] datasend;
   logic [7:0] datareceive;
   logic       sended;
   logic       received;
   logic       ack_error;
   logic       ready;
   wire        scl_bus;
   wire        sda_bus;

   logic s_scl_low = 1'b0;
   logic s_sda_low = 1'b0;

   pullup (scl_bus);
   pullup (sda_bus);
   assign scl_bus = s_scl_low ? 1'b0 : 1'bz;
   assign sda_bus = s_sda_low ? 1'b0 : 1'bz;

   i2c_master_core #(.CLK_DIV(CLK_DIV)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .rw         (rw),
      .address    (address),
      .datasend   (datasend),
      .datareceive(datareceive),
      .sended     (sended),
      .received   (received),
      .ack_error  (ack_error),
      .ready      (ready),
      .scl        (scl_bus),
      .sda        (sda_bus)
   );

   always #5 clk = ~clk;

   // Slave model state and bus log
   logic       p_scl = 1'b1;
   logic       p_sda = 1'b1;
   logic       cs;
   logic       cd;
   logic       s_active = 1'b0;
   logic       addr_ok = 1'b0;
   logic       rmode = 1'b0;
   logic       stretch_en = 1'b0;
   logic       stretch_done = 1'b0;
   logic [7:0] rx = 8'h00;
   logic [7:0] rdata = 8'h5A;
   logic [7:0] seen [4];
   logic       ack_seen [4];
   int bitn = 0;
   int byten = 0;
   int nbytes = 0;
   int scnt = 0;
   int hcount = 0;
   int stretched_high = 0;
   int start_count = 0;
   int stop_count = 0;
   int sended_cnt = 0;
   int received_cnt = 0;

   int checks = 0;
   int failures = 0;

   // Slave acts on the falling clk edge so bus values are settled
   initial forever begin
      @(negedge clk);
      cs = scl_bus;
      cd = sda_bus;
      if (s_scl_low) begin
         scnt = scnt - 1;
         if (scnt <= 0) s_scl_low = 1'b0;
      end
      if (cs) hcount = p_scl ? hcount + 1 : 1;
      if (p_scl && cs && p_sda && !cd) begin
         start_count++;
         s_active = 1'b1;
         bitn = -1;
         byten = 0;
         nbytes = 0;
         addr_ok = 1'b0;
         stretched_high = 0;
         stretch_done = 1'b0;
         s_sda_low = 1'b0;
      end else if (p_scl && cs && !p_sda && cd) begin
         stop_count++;
         s_active = 1'b0;
         s_sda_low = 1'b0;
      end else if (s_active && !p_scl && cs) begin
         if (bitn >= 0 && bitn < 8) begin
            rx = {rx[6:0], cd};
            if (bitn == 7) begin
               if (nbytes < 4) seen[nbytes] = rx;
               nbytes++;
            end
         end else if (bitn == 8 && byten < 4) begin
            ack_seen[byten] = cd;
         end
      end else if (s_active && p_scl && !cs) begin
         if (byten == 1 && bitn == 3) stretched_high = hcount;
         if (bitn == 8) begin
            bitn = 0;
            byten++;
         end else begin
            bitn++;
         end
         s_sda_low = 1'b0;
         if (bitn == 8) begin
            if (byten == 0) begin
               addr_ok = (rx[7:1] == SLAVE_ADDR);
               rmode = rx[0];
               s_sda_low = addr_ok;
            end else if (byten == 1 && addr_ok && !rmode) begin
               s_sda_low = 1'b1;
            end
         end else if (byten == 1 && addr_ok && rmode) begin
            s_sda_low = !rdata[7-bitn];
         end
         if (stretch_en && byten == 1 && bitn == 3) begin
            s_scl_low = 1'b1;
            scnt = 50;
            stretch_done = 1'b1;
         end
      end
      p_scl = cs;
      p_sda = cd;
   end

   initial forever begin
      @(negedge clk);
      if (sended) sended_cnt++;
      if (received) received_cnt++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic rw_i, input logic [6:0] addr_i, input logic [7:0] data_i);
      @(negedge clk);
      rw = rw_i;
      address = addr_i;
      datasend = data_i;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("ready_drop", 32'(ready), 32'd0);
      checkOutput("ack_error_cleared", 32'(ack_error), 32'd0);
   endtask

   task automatic waitIdle(input string tag);
      int waited = 0;
      while (!ready && waited < 3000) begin
         @(negedge clk);
         waited++;
      end
      checkOutput(tag, 32'(ready), 32'd1);
   endtask

   int base_start, base_stop, base_sended, base_received, waited;

   task automatic snapshot();
      base_start = start_count;
      base_stop = stop_count;
      base_sended = sended_cnt;
      base_received = received_cnt;
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      rw = 1'b0;
      address = 7'h00;
      datasend = 8'h00;
      repeat (3) @(negedge clk);
      checkOutput("rst_ready", 32'(ready), 32'd1);
      checkOutput("rst_sended", 32'(sended), 32'd0);
      checkOutput("rst_received", 32'(received), 32'd0);
      checkOutput("rst_ack_error", 32'(ack_error), 32'd0);
      checkOutput("rst_datareceive", 32'(datareceive), 32'h00);
      checkOutput("rst_scl", 32'(scl_bus), 32'd1);
      checkOutput("rst_sda", 32'(sda_bus), 32'd1);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      $display("[TB] write 0xA5 to 0x3C");
      snapshot();
      applyStimulus(1'b0, 7'h3C, 8'hA5);
      repeat (40) @(negedge clk);
      rw = 1'b1;
      address = 7'h11;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitIdle("wr_idle");
      checkOutput("wr_addr_byte", 32'(seen[0]), 32'h78);
      checkOutput("wr_addr_ack", 32'(ack_seen[0]), 32'd0);
      checkOutput("wr_data_byte", 32'(seen[1]), 32'hA5);
      checkOutput("wr_data_ack", 32'(ack_seen[1]), 32'd0);
      checkOutput("wr_nbytes", 32'(nbytes), 32'd2);
      checkOutput("wr_stop", 32'(stop_count - base_stop), 32'd1);
      checkOutput("wr_sended", 32'(sended_cnt - base_sended), 32'd1);
      checkOutput("wr_received", 32'(received_cnt - base_received), 32'd0);
      checkOutput("wr_ack_error", 32'(ack_error), 32'd0);
      repeat (30) @(negedge clk);
      checkOutput("busy_start_ignored", 32'(start_count - base_start), 32'd1);
      checkOutput("idle_stays_ready", 32'(ready), 32'd1);

      $display("[TB] read from 0x3C");
      snapshot();
      applyStimulus(1'b1, 7'h3C, 8'h00);
      waitIdle("rd_idle");
      checkOutput("rd_addr_byte", 32'(seen[0]), 32'h79);
      checkOutput("rd_addr_ack", 32'(ack_seen[0]), 32'd0);
      checkOutput("rd_bus_byte", 32'(seen[1]), 32'h5A);
      checkOutput("rd_master_nack", 32'(ack_seen[1]), 32'd1);
      checkOutput("rd_datareceive", 32'(datareceive), 32'h5A);
      checkOutput("rd_received", 32'(received_cnt - base_received), 32'd1);
      checkOutput("rd_sended", 32'(sended_cnt - base_sended), 32'd0);
      checkOutput("rd_stop", 32'(stop_count - base_stop), 32'd1);
      checkOutput("rd_ack_error", 32'(ack_error), 32'd0);

      $display("[TB] address NACK at 0x11");
      snapshot();
      applyStimulus(1'b0, 7'h11, 8'hFF);
      waitIdle("nack_idle");
      checkOutput("nack_addr_byte", 32'(seen[0]), 32'h22);
      checkOutput("nack_addr_ack", 32'(ack_seen[0]), 32'd1);
      checkOutput("nack_nbytes", 32'(nbytes), 32'd1);
      checkOutput("nack_ack_error", 32'(ack_error), 32'd1);
      checkOutput("nack_sended", 32'(sended_cnt - base_sended), 32'd0);
      checkOutput("nack_stop", 32'(stop_count - base_stop), 32'd1);

      $display("[TB] clock stretch on data bit 3");
      snapshot();
      stretch_en = 1'b1;
      applyStimulus(1'b0, 7'h3C, 8'hC3);
      waitIdle("str_idle");
      stretch_en = 1'b0;
      checkOutput("str_happened", 32'(stretch_done), 32'd1);
      checkOutput("str_high_full",
                  32'((stretched_high >= 2*CLK_DIV-1) && (stretched_high <= 2*CLK_DIV)), 32'd1);
      checkOutput("str_data_byte", 32'(seen[1]), 32'hC3);
      checkOutput("str_data_ack", 32'(ack_seen[1]), 32'd0);
      checkOutput("str_sended", 32'(sended_cnt - base_sended), 32'd1);
      checkOutput("str_stop", 32'(stop_count - base_stop), 32'd1);

      $display("[TB] reset during address bit 4");
      applyStimulus(1'b0, 7'h11, 8'h00);
      waited = 0;
      while (!(s_active && byten == 0 && bitn == 4) && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("reached_addr_bit4", 32'(waited < 500), 32'd1);
      repeat (2) @(negedge clk);
      checkOutput("pre_rst_scl_low", 32'(scl_bus), 32'd0);
      checkOutput("pre_rst_sda_low", 32'(sda_bus), 32'd0);
      snapshot();
      reset = 1'b0;
      #1;
      checkOutput("rst_mid_scl", 32'(scl_bus), 32'd1);
      checkOutput("rst_mid_sda", 32'(sda_bus), 32'd1);
      checkOutput("rst_mid_ready", 32'(ready), 32'd1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rst_no_stop", 32'(stop_count - base_stop), 32'd0);

      $display("[TB] clean write after reset");
      snapshot();
      applyStimulus(1'b0, 7'h3C, 8'h96);
      waitIdle("post_idle");
      checkOutput("post_start", 32'(start_count - base_start), 32'd1);
      checkOutput("post_addr_byte", 32'(seen[0]), 32'h78);
      checkOutput("post_data_byte", 32'(seen[1]), 32'h96);
      checkOutput("post_data_ack", 32'(ack_seen[1]), 32'd0);
      checkOutput("post_sended", 32'(sended_cnt - base_sended), 32'd1);
      checkOutput("post_stop", 32'(stop_count - base_stop), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
